// File: rtl/register_file_16.sv
// Eight-entry 16-bit operand register file (R1-R4, S1-S4) with per-cycle update functions and two combinational read ports.
// Optional write-to-read forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module register_file_16 (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] I,
    input  logic [2:0]  FunSel,
    input  logic [3:0]  RegSel,
    input  logic [3:0]  ScrSel,
    input  logic [2:0]  OutASel,
    input  logic [2:0]  OutBSel,
    output logic [15:0] OutA,
    output logic [15:0] OutB
);

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        FN_DEC   = 3'b000,
        FN_INC   = 3'b001,
        FN_LOAD  = 3'b010,
        FN_CLR   = 3'b011,
        FN_CLRLO = 3'b100,
        FN_LDLO  = 3'b101,
        FN_LDHI  = 3'b110,
        FN_SEXT  = 3'b111
    } fun_e;

    // Storage index matches the read-select encoding: 0..3 = R1..R4, 4..7 = S1..S4.
    logic [WIDTH-1:0] q   [8];
    logic [WIDTH-1:0] nxt [8];
    logic [7:0]       en;

    assign en = {ScrSel[0], ScrSel[1], ScrSel[2], ScrSel[3],
                 RegSel[0], RegSel[1], RegSel[2], RegSel[3]};

    function automatic logic [WIDTH-1:0] apply_fun(input logic [2:0] f,
                                                   input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = cur;
        case (fun_e'(f))
            FN_DEC:   r = cur - 16'd1;
            FN_INC:   r = cur + 16'd1;
            FN_LOAD:  r = d;
            FN_CLR:   r = '0;
            FN_CLRLO: r = {8'h00, d[7:0]};
            FN_LDLO:  r = {cur[15:8], d[7:0]};
            FN_LDHI:  r = {d[7:0], cur[7:0]};
            FN_SEXT:  r = {{8{d[7]}}, d[7:0]};
            default:  r = cur;
        endcase
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            nxt[k] = apply_fun(FunSel, q[k], I);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 8; k++) begin
                q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (en[k]) begin
                    q[k] <= nxt[k];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the pending update so the ALU can use a freshly written operand this cycle.
    assign OutA = Reset ? '0 : (en[OutASel] ? nxt[OutASel] : q[OutASel]);
    assign OutB = Reset ? '0 : (en[OutBSel] ? nxt[OutBSel] : q[OutBSel]);
`else
    assign OutA = q[OutASel];
    assign OutB = q[OutBSel];
`endif

endmodule
